// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch PC incrementer.
// Holds the default address/instruction widths, the derived byte step
// and the program-counter address type.
package if_pkg;

    localparam int NB_ADDR_DEF = 32;
    localparam int NB_INST_DEF = 32;

    // Bytes advanced per instruction at the default instruction width.
    localparam int STEP_DEF    = NB_INST_DEF / 8;

    typedef logic [NB_ADDR_DEF-1:0] pc_t;

endpackage : if_pkg

// File: rtl/if_pc_adder.sv
// Combinational PC adder: o_sum = i_a + STEP, modulo 2^NB_ADDR.
// With IF_INC_PC_OVF_EN defined, the carry out of the top bit is also
// produced on o_carry; otherwise no carry path is built.
module if_pc_adder
    import if_pkg::*;
#(
    parameter int NB_ADDR = NB_ADDR_DEF,
    parameter int STEP    = STEP_DEF
) (
    input  logic [NB_ADDR-1:0] i_a,
`ifdef IF_INC_PC_OVF_EN
    output logic               o_carry,
`endif
    output logic [NB_ADDR-1:0] o_sum
);

    // Step expressed at the address width so the add is width-matched.
    localparam logic [NB_ADDR-1:0] STEP_W = NB_ADDR'(STEP);

`ifdef IF_INC_PC_OVF_EN
    // Widened unsigned add so the carry out of the top address bit is kept.
    always_comb begin
        {o_carry, o_sum} = {1'b0, i_a} + {1'b0, STEP_W};
    end
`else
    // Plain unsigned add; the carry out of the top bit is simply dropped.
    always_comb begin
        o_sum = i_a + STEP_W;
    end
`endif

endmodule : if_pc_adder

// File: rtl/if_inc_pc.sv
// Fetch-stage PC incrementer.
// o_pc is the combinational next PC (i_pc + NB_INST/8); o_pc_q/o_valid are
// the registered copy with stall (hold) and flush (clear, wins over stall).
// Optional feature macro: IF_INC_PC_OVF_EN adds o_ovf, the combinational
// carry out of the address add.
module if_inc_pc
    import if_pkg::*;
#(
    parameter int NB_ADDR = NB_ADDR_DEF,
    parameter int NB_INST = NB_INST_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NB_ADDR-1:0] i_pc,
    input  logic               i_stall,
    input  logic               i_flush,
    output logic [NB_ADDR-1:0] o_pc,
    output logic [NB_ADDR-1:0] o_pc_q,
`ifdef IF_INC_PC_OVF_EN
    output logic               o_ovf,
`endif
    output logic               o_valid
);

    localparam int STEP = NB_INST / 8;

    // Reject configurations the byte step or address width cannot express.
    generate
        if ((NB_INST % 8) != 0) begin : g_bad_inst
            $error("if_inc_pc: NB_INST must be a multiple of 8");
        end
        if (NB_ADDR < 8) begin : g_bad_addr
            $error("if_inc_pc: NB_ADDR must be at least 8");
        end
    endgenerate

    logic [NB_ADDR-1:0] w_pc_next;
    logic [NB_ADDR-1:0] r_pc_q;
    logic               r_valid;

    if_pc_adder #(
        .NB_ADDR (NB_ADDR),
        .STEP    (STEP)
    ) u_adder (
        .i_a     (i_pc),
`ifdef IF_INC_PC_OVF_EN
        .o_carry (o_ovf),
`endif
        .o_sum   (w_pc_next)
    );

    // Next-PC register: flush clears, stall holds, otherwise capture.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc_q  <= '0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_pc_q  <= '0;
            r_valid <= 1'b0;
        end else if (!i_stall) begin
            r_pc_q  <= w_pc_next;
            r_valid <= 1'b1;
        end else begin
            r_pc_q  <= r_pc_q;
            r_valid <= r_valid;
        end
    end

    // Combinational next PC is independent of clock, reset, stall and flush.
    always_comb begin
        o_pc    = w_pc_next;
        o_pc_q  = r_pc_q;
        o_valid = r_valid;
    end

endmodule : if_inc_pc

// File: tb/tb_if_inc_pc.sv
// Self-checking bench for if_inc_pc (default 32-bit address/instruction).
// Expected values come from a small arithmetic reference model.
module tb_if_inc_pc;
    import if_pkg::*;

    localparam longint MOD   = 64'h1_0000_0000;
    localparam longint STEPL = 64'd4;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic [31:0] o_pc;
    logic [31:0] o_pc_q;
    logic        o_valid;
`ifdef IF_INC_PC_OVF_EN
    logic        o_ovf;
`endif

    int total = 0;
    int bad   = 0;

    // Reference state for the registered stage.
    longint ref_q = 0;
    bit     ref_v = 1'b0;

    if_inc_pc dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_pc    (pc),
        .i_stall (stall),
        .i_flush (flush),
        .o_pc    (o_pc),
        .o_pc_q  (o_pc_q),
`ifdef IF_INC_PC_OVF_EN
        .o_ovf   (o_ovf),
`endif
        .o_valid (o_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Combinational outputs for the currently driven pc.
    task automatic chk_comb(input string tag);
        longint sum;
        sum = longint'(pc) + STEPL;
        chk({tag, "_pc"}, longint'(o_pc), sum % MOD);
`ifdef IF_INC_PC_OVF_EN
        chk({tag, "_ovf"}, longint'(o_ovf), (sum >= MOD) ? 64'd1 : 64'd0);
`endif
    endtask

    // Drive inputs on the falling edge, then check the zero-latency output.
    task automatic drive(input logic [31:0] p, input logic s, input logic f, input string tag);
        @(negedge clk);
        pc = p; stall = s; flush = f;
        #1;
        chk_comb(tag);
    endtask

    // One rising edge: advance the model, then check the registered outputs.
    task automatic edge_chk(input string tag);
        @(posedge clk);
        if (!rst_n) begin
            ref_q = 0; ref_v = 1'b0;
        end else if (flush) begin
            ref_q = 0; ref_v = 1'b0;
        end else if (!stall) begin
            ref_q = (longint'(pc) + STEPL) % MOD;
            ref_v = 1'b1;
        end
        #1;
        chk({tag, "_q"}, longint'(o_pc_q), ref_q);
        chk({tag, "_v"}, longint'(o_valid), longint'(ref_v));
    endtask

    initial begin
        rst_n = 1'b0; pc = 32'h0000_0100; stall = 1'b0; flush = 1'b0;
        #2;
        chk("reset_q", longint'(o_pc_q), 64'd0);
        chk("reset_v", longint'(o_valid), 64'd0);
        chk_comb("reset_comb");
        edge_chk("reset_edge");

        // Release reset between edges; first capture on the next rising edge.
        drive(32'h0000_0008, 1'b0, 1'b0, "pc08");
        rst_n = 1'b1;
        edge_chk("pc08");
        chk("pc08_lit", longint'(o_pc_q), 64'h0000_000C);

        drive(32'h0000_0020, 1'b0, 1'b0, "pc20");
        chk("pc20_lit", longint'(o_pc), 64'h0000_0024);
        edge_chk("pc20");

        drive(32'hFFFF_FFFC, 1'b0, 1'b0, "wrap");
        chk("wrap_lit", longint'(o_pc), 64'd0);
`ifdef IF_INC_PC_OVF_EN
        chk("wrap_ovf_lit", longint'(o_ovf), 64'd1);
`endif
        edge_chk("wrap");

        drive(32'h0000_0003, 1'b0, 1'b0, "unal");
        chk("unal_lit", longint'(o_pc), 64'h0000_0007);
        edge_chk("unal");

        // Capture 0x10, then stall with a new pc for three edges.
        drive(32'h0000_0010, 1'b0, 1'b0, "cap10");
        edge_chk("cap10");
        for (int i = 0; i < 3; i++) begin
            drive(32'h0000_0040, 1'b1, 1'b0, "stall");
            edge_chk("stall");
            chk("stall_lit", longint'(o_pc_q), 64'h0000_0014);
        end
        drive(32'h0000_0040, 1'b0, 1'b0, "release");
        edge_chk("release");
        chk("release_lit", longint'(o_pc_q), 64'h0000_0044);

        // Flush together with stall clears the register.
        drive(32'h0000_0080, 1'b1, 1'b1, "flush_stall");
        edge_chk("flush_stall");
        chk("flush_lit_v", longint'(o_valid), 64'd0);

        // Randomized traffic with occasional stall, flush and wrap-range pcs.
        for (int i = 0; i < 200; i++) begin
            logic [31:0] rp;
            rp = $urandom;
            if ($urandom_range(0, 7) == 0) rp = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            drive(rp, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), "rand");
            edge_chk("rand");
        end

        // Asynchronous reset between edges clears at once; o_pc keeps tracking.
        drive(32'h0000_1000, 1'b0, 1'b0, "pre_rst");
        edge_chk("pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_q", longint'(o_pc_q), 64'd0);
        chk("async_v", longint'(o_valid), 64'd0);
        ref_q = 0; ref_v = 1'b0;
        pc = 32'h0000_2000;
        #1;
        chk_comb("async_comb");
        edge_chk("in_rst");
        drive(32'h0000_3000, 1'b0, 1'b0, "post_rst");
        rst_n = 1'b1;
        edge_chk("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_if_inc_pc
